// File: rtl/cmos_pkg.sv
// cmos_pkg: shared widths, FSM encoding and pixel word type for the OV7670
// capture path feeding the SDRAM frame buffer.
package cmos_pkg;

    localparam int PIX_W  = 10;
    localparam int LINE_W = 9;
    localparam int SKIP_W = 8;
    localparam int BYTE_W = 11;

    // Capture FSM encoding: WAIT_INIT -> SKIP -> WAIT_VS <-> ACTIVE.
    localparam logic [1:0] ST_WAIT_INIT = 2'd0;
    localparam logic [1:0] ST_SKIP      = 2'd1;
    localparam logic [1:0] ST_WAIT_VS   = 2'd2;
    localparam logic [1:0] ST_ACTIVE    = 2'd3;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/cmos_byte_pack.sv
// cmos_byte_pack: registers the sensor bus, detects vsync/href edges and pairs
// bytes into RGB565 words with a registered write strobe.
module cmos_byte_pack
    import cmos_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_i,
    input  logic       href_i,
    input  logic [7:0] data_i,
    input  logic       wr_allow_i,
    output logic       href_o,
    output logic       vs_rise_o,
    output logic       vs_fall_o,
    output logic       href_rise_o,
    output logic       href_fall_o,
    output logic       pair_o,
    output logic       odd_drop_o,
    output logic       sys_we_o,
    output rgb565_t    sys_data_o
);

    logic       vs_q;
    logic       vs_prev_q;
    logic       href_q;
    logic       href_prev_q;
    logic [7:0] data_q;
    logic [7:0] hi_q;
    logic       phase_q;
    logic       phase_cur;
    logic       we_q;
    rgb565_t    word_q;

    assign vs_rise_o   = vs_q & ~vs_prev_q;
    assign vs_fall_o   = ~vs_q & vs_prev_q;
    assign href_rise_o = href_q & ~href_prev_q;
    assign href_fall_o = ~href_q & href_prev_q;
    assign href_o      = href_q;

    // A new line always starts on the high byte.
    assign phase_cur  = href_rise_o ? 1'b0 : phase_q;
    assign pair_o     = href_q & phase_cur;
    assign odd_drop_o = href_fall_o & phase_q;

    assign sys_we_o   = we_q;
    assign sys_data_o = word_q;

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset as well, so sys_data_in reads 0 after rst.
        if (rst) begin
            vs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            href_q      <= 1'b0;
            href_prev_q <= 1'b0;
            data_q      <= '0;
            hi_q        <= '0;
            phase_q     <= 1'b0;
            we_q        <= 1'b0;
            word_q      <= '0;
        end else begin
            vs_q        <= vsync_i;
            vs_prev_q   <= vs_q;
            href_q      <= href_i;
            href_prev_q <= href_q;
            data_q      <= data_i;
            phase_q     <= href_q ? ~phase_cur : 1'b0;
            if (href_q && !phase_cur) begin
                hi_q <= data_q;
            end
            we_q <= pair_o & wr_allow_i;
            if (pair_o && wr_allow_i) begin
                word_q <= {hi_q, data_q};
            end
        end
    end

endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: OV7670 frame writer into the SDRAM frame buffer write port.
// Optional geometry checking on cap_err is enabled by defining CMOS_CAPTURE_CHECK_EN.
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int H_PIXELS    = 480,
    parameter int V_LINES     = 272,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        sys_we,
    output logic [15:0] sys_data_in,
    output logic        frame_valid,
    output logic        frame_done,
    output logic        cap_err
);

    localparam logic [PIX_W-1:0]  H_MAX     = PIX_W'(H_PIXELS);
    localparam logic [LINE_W-1:0] V_MAX     = LINE_W'(V_LINES);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES - 1);

    logic              init_q;
    logic [1:0]        state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [PIX_W-1:0]  pix_q, pix_d, pix_cur;
    logic [LINE_W-1:0] line_q, line_d;
    logic              fv_q, fv_d;
    logic              fd_q, fd_d;
    logic              abort;
    logic              wr_allow;

    logic              href_lvl;
    logic              vs_rise, vs_fall, href_rise, href_fall;
    logic              pair, odd_drop;
    rgb565_t           sys_word;

    cmos_byte_pack u_pack (
        .clk         (clk),
        .rst         (rst),
        .vsync_i     (cmos_vsync),
        .href_i      (cmos_href),
        .data_i      (cmos_data),
        .wr_allow_i  (wr_allow),
        .href_o      (href_lvl),
        .vs_rise_o   (vs_rise),
        .vs_fall_o   (vs_fall),
        .href_rise_o (href_rise),
        .href_fall_o (href_fall),
        .pair_o      (pair),
        .odd_drop_o  (odd_drop),
        .sys_we_o    (sys_we),
        .sys_data_o  (sys_word)
    );

    assign sys_data_in = sys_word;
    assign frame_valid = fv_q;
    assign frame_done  = fd_q;

    assign abort    = (state_q != ST_WAIT_INIT) && !init_q;
    assign pix_cur  = href_rise ? '0 : pix_q;
    assign wr_allow = (state_q == ST_ACTIVE) && (pix_cur < H_MAX) && (line_q < V_MAX);

    always_comb begin
        // NOTE: every _d starts from its hold value so no path can infer a latch.
        state_d = state_q;
        skip_d  = skip_q;
        pix_d   = pix_q;
        line_d  = line_q;
        fv_d    = fv_q;
        fd_d    = 1'b0;

        case (state_q)
            ST_WAIT_INIT: begin
                fv_d = 1'b0;
                if (init_q) begin
                    state_d = ST_SKIP;
                    skip_d  = '0;
                end
            end
            ST_SKIP: begin
                if (vs_fall) begin
                    if (skip_q >= SKIP_LAST) begin
                        state_d = ST_WAIT_VS;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
            end
            ST_WAIT_VS: begin
                if (vs_fall) begin
                    state_d = ST_ACTIVE;
                    fv_d    = 1'b1;
                    line_d  = '0;
                    pix_d   = '0;
                end
            end
            ST_ACTIVE: begin
                pix_d = pix_cur;
                if (pair && pix_cur < H_MAX) begin
                    pix_d = pix_cur + 1'b1;
                end
                if (href_fall && line_q < V_MAX) begin
                    line_d = line_q + 1'b1;
                end
                if (vs_rise) begin
                    state_d = ST_WAIT_VS;
                    fv_d    = 1'b0;
                    fd_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_INIT;
                fv_d    = 1'b0;
            end
        endcase

        // Losing the frame buffer mid-frame discards the frame without frame_done.
        if (abort) begin
            state_d = ST_WAIT_INIT;
            fv_d    = 1'b0;
            fd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q  <= 1'b0;
            state_q <= ST_WAIT_INIT;
            skip_q  <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            fv_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            init_q  <= sdram_init_done;
            state_q <= state_d;
            skip_q  <= skip_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            fv_q    <= fv_d;
            fd_q    <= fd_d;
        end
    end

`ifdef CMOS_CAPTURE_CHECK_EN
    localparam logic [BYTE_W-1:0] BYTE_EXP = BYTE_W'(2 * H_PIXELS);

    logic [BYTE_W-1:0] byte_q, byte_d, byte_cur;
    logic              line_bad_q, line_bad_d;
    logic              err_q, err_d;

    always_comb begin
        byte_cur   = href_rise ? '0 : byte_q;
        byte_d     = byte_q;
        line_bad_d = line_bad_q;
        err_d      = err_q;
        if (href_lvl) begin
            byte_d = (&byte_cur) ? byte_cur : byte_cur + 1'b1;
        end
        if (state_q == ST_WAIT_VS && vs_fall) begin
            line_bad_d = 1'b0;
        end
        if (state_q == ST_ACTIVE && href_fall && (byte_q != BYTE_EXP || odd_drop)) begin
            line_bad_d = 1'b1;
        end
        if (state_q == ST_ACTIVE && vs_rise && !abort && (line_bad_q || line_q != V_MAX)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q     <= '0;
            line_bad_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_q     <= byte_d;
            line_bad_q <= line_bad_d;
            err_q      <= err_d;
        end
    end

    assign cap_err = err_q;
`else
    logic unused_chk;
    assign unused_chk = odd_drop ^ href_lvl;
    assign cap_err    = 1'b0;
`endif

endmodule

// File: doc/cmos_capture.md
# cmos_capture

Camera-side frame writer for the OV7670 display path. Samples the sensor's 8-bit parallel bus (vsync/href/data) on the pixel clock, discards the sensor's first unstable frames, packs byte pairs into RGB565 words and drives the write FIFO interface of the SDRAM frame buffer (sys_we/sys_data_in) plus the frame_valid level consumed by the bank switcher. It is the producer end of the frame buffer whose consumer is the LCD reader.

## Interface
- H_PIXELS, 480: RGB565 words written per line.
- V_LINES, 272: lines written per frame.
- SKIP_FRAMES, 10: complete frames discarded after init before capture starts (1..255).
- clk  in  1  sensor pixel clock (same clock as clk_write of the frame buffer).
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- sdram_init_done  in  1  frame buffer ready; capture is gated by it.
- cmos_vsync  in  1  sensor vsync, high during vertical blanking.
- cmos_href  in  1  sensor line valid, high while bytes are valid.
- cmos_data  in  8  sensor byte bus.
- sys_we  out  1  one-cycle write strobe per packed word.
- sys_data_in  out  16  packed RGB565 word, valid when sys_we=1.
- frame_valid  out  1  high for the duration of each captured frame.
- frame_done  out  1  one-cycle pulse when a captured frame ends.
- cap_err  out  1  sticky geometry error (see Configuration).

## Operation
- All cmos_* inputs pass through one register stage before any use; edges detected on the registered copies.
- States: WAIT_INIT -> SKIP -> WAIT_VS -> ACTIVE -> WAIT_VS ...
- WAIT_INIT: all outputs low; leave when sdram_init_done=1.
- SKIP: count vsync falling edges; after SKIP_FRAMES of them, go to WAIT_VS (the falling edge that completes the count does not start capture).
- WAIT_VS: on vsync falling edge go to ACTIVE, assert frame_valid.
- ACTIVE: on href rising edge clear byte phase and pixel counter. While href=1: even phase byte -> sys_data_in[15:8], odd phase byte -> [7:0] and strobe sys_we if pixel count < H_PIXELS and line count < V_LINES; pixel counter saturates at H_PIXELS. Line counter increments on href falling edge, saturates at V_LINES.
- vsync rising edge in ACTIVE: drop frame_valid, pulse frame_done, go WAIT_VS.
- sdram_init_done falling in any state except WAIT_INIT: abort, frame_valid low, no frame_done, go WAIT_INIT; SKIP restarts from zero.
- href falling with odd byte phase: held high byte dropped, no write.
- Counters: pixel 10-bit, line 9-bit, skip 8-bit; no wrap (saturating).

## Timing
- Reset values: sys_we=0, sys_data_in=0, frame_valid=0, frame_done=0, cap_err=0, state WAIT_INIT.
- sys_we asserted exactly 2 cycles after the cycle in which the low byte is present on cmos_data; sys_data_in changes only with sys_we.
- Back-to-back pixels: sys_we every second cycle, never in consecutive cycles.
- frame_valid rises 2 cycles after cmos_vsync falls, falls 2 cycles after it rises; frame_done coincides with the falling cycle.
- The last sys_we of a frame precedes frame_valid fall by at least 1 cycle.
- Reset mid-frame: outputs zero the following cycle; capture cannot resume mid-frame (needs WAIT_INIT, SKIP and a vsync falling edge).

## Configuration
- CMOS_CAPTURE_CHECK_EN defined: at each vsync rising edge in ACTIVE, cap_err set if any line had byte count != 2*H_PIXELS or line count != V_LINES or an odd-phase drop occurred; cleared only by rst.
- Not defined: checking logic absent, cap_err tied 0; write behaviour identical.

## Structure
- Shared package cmos_pkg: state enum (WAIT_INIT, SKIP, WAIT_VS, ACTIVE), counter widths, RGB565 word typedef.
- One sub-module cmos_byte_pack (input register, edge detect, byte pairing, sys_we generation); the FSM and counters stay in the top.

## Test plan
- SKIP_FRAMES=2, init_done=1, 4 frames of 480x272 -> frame_valid only for frames 3,4; exactly 130560 sys_we per captured frame; 2 frame_done pulses.
- Bytes 0xF8,0x1F on one pixel -> sys_data_in=16'hF81F with sys_we 2 cycles after 0x1F presented.
- Line with 961 bytes -> 480 writes, trailing byte dropped; cap_err=1 after vsync rise (macro on), 0 (macro off).
- 300 lines of 500 pixels -> 480 writes/line, writes stop after line 272; frame_done still pulses.
- init_done deasserted mid-frame -> frame_valid low next cycle+1, no frame_done, capture resumes only after 2 skipped frames once init_done returns.
- rst asserted mid-line -> all outputs 0 next cycle, no sys_we until a full SKIP sequence completes.
